mem_controller_rr: RTL and testbench

//  Multi-channel memory controller arbitrating NUM_CONSUMERS fetchers/LSUs onto NUM_CHANNELS external

---
 rtl/mem_ctrl_pkg.sv | 17 +
 rtl/mem_ctrl_rr_pick.sv | 35 +++
 rtl/mem_controller_rr.sv | 162 ++++++++++++++++
 tb/tb_mem_controller_rr.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the round-robin multi-channel memory controller.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        READ_WAIT   = 3'd1,
        WRITE_WAIT  = 3'd2,
        READ_RELAY  = 3'd3,
        WRITE_RELAY = 3'd4
    } ctrl_state_e;

    // Consumer index width; never below one bit so a two-consumer build still has an index.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_ctrl_rr_pick.sv
// Combinational round-robin picker: first eligible consumer at or after rr_ptr, wrapping mod N.
module mem_ctrl_rr_pick
    import mem_ctrl_pkg::*;
#(
    parameter int NUM_CONSUMERS = 4,
    parameter int IDX_W         = idx_width(NUM_CONSUMERS)
) (
    input  logic [NUM_CONSUMERS-1:0] eligible,
    input  logic [IDX_W-1:0]         rr_ptr,
    output logic                     found,
    output logic [IDX_W-1:0]         index
);

    localparam logic [IDX_W:0] N_W = (IDX_W+1)'(NUM_CONSUMERS);

    logic [IDX_W:0] cand;

    // Explicit wrap keeps non-power-of-two consumer counts in range.
    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = '0;
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand >= N_W) begin
                cand = cand - N_W;
            end
            if (!found && eligible[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                index = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_controller_rr.sv
// Multi-channel memory controller: round-robin consumer arbitration onto NUM_CHANNELS memory
// channels with single-channel ownership per consumer and read-before-write on the same consumer.
module mem_controller_rr
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                 mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                 mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]                 mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                 mem_write_ready,
    output logic [NUM_CHANNELS-1:0]                 channel_busy,
    output ctrl_state_e [NUM_CHANNELS-1:0]          channel_state
);

    // Handshake: a consumer holds valid (and its address/data) until it sees ready; the
    // controller then holds ready until valid drops. The memory side raises ready for the
    // channel's outstanding request; ready outside a WAIT state carries no meaning.

    localparam int              IDX_W    = idx_width(NUM_CONSUMERS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CONSUMERS - 1);

    logic [NUM_CHANNELS-1:0][IDX_W-1:0] owner;
    logic [NUM_CONSUMERS-1:0]           owned;
    logic [IDX_W-1:0]                   rr_ptr;
    logic [NUM_CONSUMERS-1:0]           write_req;
    logic [NUM_CONSUMERS-1:0]           avail [NUM_CHANNELS+1];
    logic [NUM_CHANNELS-1:0]            pick_found;
    logic [NUM_CHANNELS-1:0]            grant;
    logic [IDX_W-1:0]                   pick_idx [NUM_CHANNELS];
    logic                               any_grant;
    logic [IDX_W-1:0]                   last_idx;
    logic [IDX_W-1:0]                   rr_next;

    assign write_req = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;
    assign avail[0]  = (consumer_read_valid | write_req) & ~owned;

    // Channels pick in ascending order; each removes its grant from the mask seen by the next.
    for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_chan
        mem_ctrl_rr_pick #(
            .NUM_CONSUMERS(NUM_CONSUMERS),
            .IDX_W        (IDX_W)
        ) u_pick (
            .eligible(avail[ch]),
            .rr_ptr  (rr_ptr),
            .found   (pick_found[ch]),
            .index   (pick_idx[ch])
        );

        assign grant[ch]      = pick_found[ch] && (channel_state[ch] == IDLE);
        assign avail[ch+1]    = grant[ch] ? (avail[ch] & ~(NUM_CONSUMERS'(1) << pick_idx[ch]))
                                          : avail[ch];
        assign channel_busy[ch] = (channel_state[ch] != IDLE);
    end

    always_comb begin
        any_grant = 1'b0;
        last_idx  = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (grant[ch]) begin
                any_grant = 1'b1;
                last_idx  = pick_idx[ch];
            end
        end
        rr_next = (last_idx == LAST_IDX) ? '0 : last_idx + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                channel_state[ch] <= IDLE;
            end
            owner                <= '0;
            owned                <= '0;
            rr_ptr               <= '0;
            consumer_read_ready  <= '0;
            consumer_read_data   <= '0;
            consumer_write_ready <= '0;
            mem_read_valid       <= '0;
            mem_read_address     <= '0;
            mem_write_valid      <= '0;
            mem_write_address    <= '0;
            mem_write_data       <= '0;
        end else begin
            if (any_grant) begin
                rr_ptr <= rr_next;
            end
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                case (channel_state[ch])
                    IDLE: begin
                        if (grant[ch]) begin
                            owner[ch]              <= pick_idx[ch];
                            owned[pick_idx[ch]]    <= 1'b1;
                            // A consumer asking for both is served its read first.
                            if (consumer_read_valid[pick_idx[ch]]) begin
                                channel_state[ch]    <= READ_WAIT;
                                mem_read_valid[ch]   <= 1'b1;
                                mem_read_address[ch] <= consumer_read_address[pick_idx[ch]];
                            end else if (WRITE_ENABLE != 0) begin
                                channel_state[ch]     <= WRITE_WAIT;
                                mem_write_valid[ch]   <= 1'b1;
                                mem_write_address[ch] <= consumer_write_address[pick_idx[ch]];
                                mem_write_data[ch]    <= consumer_write_data[pick_idx[ch]];
                            end
                        end
                    end
                    READ_WAIT: begin
                        if (mem_read_ready[ch]) begin
                            mem_read_valid[ch]              <= 1'b0;
                            consumer_read_ready[owner[ch]]  <= 1'b1;
                            consumer_read_data[owner[ch]]   <= mem_read_data[ch];
                            channel_state[ch]               <= READ_RELAY;
                        end
                    end
                    WRITE_WAIT: begin
                        if (mem_write_ready[ch]) begin
                            mem_write_valid[ch]             <= 1'b0;
                            consumer_write_ready[owner[ch]] <= 1'b1;
                            channel_state[ch]               <= WRITE_RELAY;
                        end
                    end
                    READ_RELAY: begin
                        if (!consumer_read_valid[owner[ch]]) begin
                            consumer_read_ready[owner[ch]] <= 1'b0;
                            owned[owner[ch]]               <= 1'b0;
                            channel_state[ch]              <= IDLE;
                        end
                    end
                    WRITE_RELAY: begin
                        if (!consumer_write_valid[owner[ch]]) begin
                            consumer_write_ready[owner[ch]] <= 1'b0;
                            owned[owner[ch]]                <= 1'b0;
                            channel_state[ch]               <= IDLE;
                        end
                    end
                    default: begin
                        channel_state[ch] <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_controller_rr.sv
// Directed bench for mem_controller_rr: one 1-channel read/write build, one 2-channel build,
// one read-only build, with small memory and consumer responders.
module tb_mem_controller_rr;
    import mem_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // 1-channel read/write instance
    logic [3:0]       a_crv, a_cwv, a_crr, a_cwr;
    logic [3:0][7:0]  a_cra, a_cwa;
    logic [3:0][15:0] a_crd, a_cwd;
    logic [0:0]       a_mrv, a_mrr, a_mwv, a_mwr, a_busy;
    logic [0:0][7:0]  a_mra, a_mwa;
    logic [0:0][15:0] a_mrd, a_mwd;
    ctrl_state_e [0:0] a_state;

    // 2-channel instance
    logic [3:0]       b_crv, b_cwv, b_crr, b_cwr;
    logic [3:0][7:0]  b_cra, b_cwa;
    logic [3:0][15:0] b_crd, b_cwd;
    logic [1:0]       b_mrv, b_mrr, b_mwv, b_mwr, b_busy;
    logic [1:0][7:0]  b_mra, b_mwa;
    logic [1:0][15:0] b_mrd, b_mwd;
    ctrl_state_e [1:0] b_state;

    // read-only instance
    logic [3:0]       r_crv, r_cwv, r_crr, r_cwr;
    logic [3:0][7:0]  r_cra, r_cwa;
    logic [3:0][15:0] r_crd, r_cwd;
    logic [0:0]       r_mrv, r_mrr, r_mwv, r_mwr, r_busy;
    logic [0:0][7:0]  r_mra, r_mwa;
    logic [0:0][15:0] r_mrd, r_mwd;
    ctrl_state_e [0:0] r_state;

    mem_controller_rr #(.NUM_CHANNELS(1), .WRITE_ENABLE(1)) dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(a_crv), .consumer_read_address(a_cra),
        .consumer_read_ready(a_crr), .consumer_read_data(a_crd),
        .consumer_write_valid(a_cwv), .consumer_write_address(a_cwa),
        .consumer_write_data(a_cwd), .consumer_write_ready(a_cwr),
        .mem_read_valid(a_mrv), .mem_read_address(a_mra),
        .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
        .mem_write_valid(a_mwv), .mem_write_address(a_mwa), .mem_write_data(a_mwd),
        .mem_write_ready(a_mwr), .channel_busy(a_busy), .channel_state(a_state)
    );

    mem_controller_rr #(.NUM_CHANNELS(2), .WRITE_ENABLE(1)) dut_2ch (
        .clk(clk), .reset(reset),
        .consumer_read_valid(b_crv), .consumer_read_address(b_cra),
        .consumer_read_ready(b_crr), .consumer_read_data(b_crd),
        .consumer_write_valid(b_cwv), .consumer_write_address(b_cwa),
        .consumer_write_data(b_cwd), .consumer_write_ready(b_cwr),
        .mem_read_valid(b_mrv), .mem_read_address(b_mra),
        .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
        .mem_write_valid(b_mwv), .mem_write_address(b_mwa), .mem_write_data(b_mwd),
        .mem_write_ready(b_mwr), .channel_busy(b_busy), .channel_state(b_state)
    );

    mem_controller_rr #(.NUM_CHANNELS(1), .WRITE_ENABLE(0)) dut_ro (
        .clk(clk), .reset(reset),
        .consumer_read_valid(r_crv), .consumer_read_address(r_cra),
        .consumer_read_ready(r_crr), .consumer_read_data(r_crd),
        .consumer_write_valid(r_cwv), .consumer_write_address(r_cwa),
        .consumer_write_data(r_cwd), .consumer_write_ready(r_cwr),
        .mem_read_valid(r_mrv), .mem_read_address(r_mra),
        .mem_read_ready(r_mrr), .mem_read_data(r_mrd),
        .mem_write_valid(r_mwv), .mem_write_address(r_mwa), .mem_write_data(r_mwd),
        .mem_write_ready(r_mwr), .channel_busy(r_busy), .channel_state(r_state)
    );

    logic [31:0] exp_q[$];
    logic [31:0] served_q[$];
    logic [23:0] wr_log[$];
    int          rd_more [4];
    int          rd_cnt = 0;

    // Memory model for the 1-channel instance: reads answer 2 cycles after valid, writes after 1.
    always @(negedge clk) begin
        if (reset) begin
            rd_cnt = 0;
            a_mrr  = '0;
            a_mwr  = '0;
        end else begin
            if (a_mrr[0]) begin
                a_mrr[0] = 1'b0;
            end else if (a_mrv[0]) begin
                rd_cnt++;
                if (rd_cnt == 2) begin
                    rd_cnt   = 0;
                    a_mrr[0] = 1'b1;
                    a_mrd[0] = 16'h1000 + {8'h00, a_mra[0]};
                end
            end
            if (a_mwr[0]) begin
                a_mwr[0] = 1'b0;
            end else if (a_mwv[0]) begin
                a_mwr[0] = 1'b1;
                wr_log.push_back({a_mwa[0], a_mwd[0]});
            end
        end
    end

    // Consumer model: drop valid on ready, log read data, optionally re-issue the next address.
    always @(negedge clk) begin
        if (!reset) begin
            for (int j = 0; j < 4; j++) begin
                if (a_crv[j] && a_crr[j]) begin
                    served_q.push_back({8'(j), 8'h00, a_crd[j]});
                    a_crv[j] = 1'b0;
                end else if (!a_crv[j] && !a_crr[j] && rd_more[j] > 0) begin
                    rd_more[j]--;
                    a_cra[j] = a_cra[j] + 8'h01;
                    a_crv[j] = 1'b1;
                end
                if (a_cwv[j] && a_cwr[j]) begin
                    a_cwv[j] = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_served(input string tag, input int n);
        int k = 0;
        while (served_q.size() < n && k < 200) begin
            tick();
            k++;
        end
        check(tag, served_q.size(), n);
    endtask

    task automatic compare_served(input string tag);
        logic [31:0] e;
        logic [31:0] o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (served_q.size() > 0) ? served_q.pop_front() : 32'hDEAD_DEAD;
            check(tag, o, e);
        end
        served_q.delete();
    endtask

    initial begin
        a_crv = '0; a_cwv = '0; a_cra = '0; a_cwa = '0; a_cwd = '0;
        a_mrr = '0; a_mrd = '0; a_mwr = '0;
        b_crv = '0; b_cwv = '0; b_cra = '0; b_cwa = '0; b_cwd = '0;
        b_mrr = '0; b_mrd = '0; b_mwr = '0;
        r_crv = '0; r_cwv = '0; r_cra = '0; r_cwa = '0; r_cwd = '0;
        r_mrr = '0; r_mrd = '0; r_mwr = '0;
        for (int j = 0; j < 4; j++) rd_more[j] = 0;

        // Reset state
        #2 reset = 1'b1;
        #1;
        check("reset_a_outs", {a_mrv, a_mwv, a_busy, a_crr, a_cwr}, 32'h0);
        check("reset_a_state", 32'(a_state[0]), 32'(IDLE));
        check("reset_b_busy", 32'(b_busy), 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tick();

        // 2 channels, only consumer 3 requesting: exactly channel 0 takes it
        b_cra[3] = 8'h77;
        b_crv[3] = 1'b1;
        tick();
        check("2ch_busy", 32'(b_busy), 32'h1);
        check("2ch_mrv", 32'(b_mrv), 32'h1);
        check("2ch_addr0", 32'(b_mra[0]), 32'h77);
        repeat (3) tick();
        check("2ch_busy_hold", 32'(b_busy), 32'h1);
        check("2ch_state1", 32'(b_state[1]), 32'(IDLE));

        // Read-only build ignores writes entirely
        r_cwa = {8'h11, 8'h22, 8'h33, 8'h44};
        r_cwd = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
        r_cwv = 4'hF;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("ro_write_outs", {r_mwv, r_mwa, r_mwd, r_cwr, r_busy}, 32'h0);
        end
        r_cwv = 4'h0;

        // Four simultaneous reads on one channel: granted 0,1,2,3
        for (int j = 0; j < 4; j++) begin
            a_cra[j] = 8'h40 + 8'(j);
            exp_q.push_back({8'(j), 8'h00, 16'h1040 + 16'(j)});
        end
        a_crv = 4'hF;
        tick();
        check("t1_mrv", 32'(a_mrv), 32'h1);
        check("t1_addr", 32'(a_mra[0]), 32'h40);
        check("t1_state", 32'(a_state[0]), 32'(READ_WAIT));
        tick();
        check("t1_not_ready_yet", 32'(a_crr), 32'h0);
        tick();
        check("t1_cons_ready", 32'(a_crr), 32'h1);
        check("t1_cons_data", 32'(a_crd[0]), 32'h1040);
        check("t1_mrv_drop", 32'(a_mrv), 32'h0);
        wait_served("t1_served_cnt", 4);
        compare_served("t1_order");
        repeat (4) tick();

        // Consumer 1 streams two reads, consumer 2 arrives during the first: 1, 2, 1
        a_cra[1]   = 8'h50;
        rd_more[1] = 1;
        a_crv[1]   = 1'b1;
        tick();
        a_cra[2] = 8'h60;
        a_crv[2] = 1'b1;
        exp_q.push_back({8'd1, 8'h00, 16'h1050});
        exp_q.push_back({8'd2, 8'h00, 16'h1060});
        exp_q.push_back({8'd1, 8'h00, 16'h1051});
        wait_served("t2_served_cnt", 3);
        compare_served("t2_order");
        repeat (4) tick();

        // Read and write both pending on consumer 0: read first, then the write
        a_cra[0] = 8'h10;
        a_cwa[0] = 8'h20;
        a_cwd[0] = 16'hBEEF;
        a_crv[0] = 1'b1;
        a_cwv[0] = 1'b1;
        exp_q.push_back({8'd0, 8'h00, 16'h1010});
        wait_served("t4_read_cnt", 1);
        check("t4_no_write_yet", 32'(wr_log.size()), 32'h0);
        check("t4_mwv_idle", 32'(a_mwv), 32'h0);
        compare_served("t4_read");
        for (int k = 0; k < 50 && wr_log.size() == 0; k++) tick();
        check("t4_write_cnt", 32'(wr_log.size()), 32'h1);
        check("t4_write_entry", (wr_log.size() > 0) ? 32'(wr_log.pop_front()) : 32'hDEAD_DEAD,
              32'h20BEEF);
        repeat (4) tick();
        check("t4_write_done", {a_cwv, a_cwr, a_busy}, 32'h0);

        // Reset during READ_WAIT: everything clears at once and nothing is delivered later
        a_cra[3] = 8'h33;
        a_crv[3] = 1'b1;
        tick();
        check("t6_in_wait", 32'(a_state[0]), 32'(READ_WAIT));
        reset = 1'b1;
        #1;
        check("t6_outs_cleared", {a_mrv, a_mra, a_busy, a_crr, a_cwr}, 32'h0);
        check("t6_state_idle", 32'(a_state[0]), 32'(IDLE));
        check("t6_2ch_cleared", {b_mrv, b_busy}, 32'h0);
        a_crv = '0;
        b_crv = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) tick();
        check("t6_no_response", {a_crr, a_mrv, a_busy}, 32'h0);
        check("t6_served_none", 32'(served_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
